// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: holds the PC, issues
// req/ack fetches to instruction memory, and hands each fetched instruction
// with its PC to decode, applying branch redirects (including during a fetch).
// Latency: instruction appears on inst_out one cycle after its imem_ack;
// back-to-back fetches run at 1 per cycle with a combinational ack.
// Backpressure: stall blocks starting a new fetch (an outstanding fetch
// always completes); halt stops fetching until reset.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall, halt             pipeline stall / permanent stop
//   branch_taken/_target    redirect request and address
//   imem_req/addr/ack/rdata instruction memory handshake
//   inst_valid/out/pc       fetched instruction to decode (inst_pc feeds branch adder)
//   halted                  high once fetching has stopped
module pc_fetch_unit #(
  parameter int                         INST_ADDR_WIDTH = 9,
  parameter int                         INST_WIDTH      = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       halt,
  input  logic                       branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  output logic                       halted
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_REQ,
    ST_HALT
  } state_t;

  localparam logic [INST_ADDR_WIDTH-1:0] PC_ONE = {{(INST_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state;
  state_t                     state_nxt;
  logic [INST_ADDR_WIDTH-1:0] pc_q;
  logic                       pend_valid;
  logic [INST_ADDR_WIDTH-1:0] pend_tgt;
  logic                       redirect;

  // A fetch is squashed if a redirect arrives with the ack or was latched
  // while the fetch was outstanding.
  assign redirect  = branch_taken | pend_valid;
  assign imem_addr = pc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; halt/stall are only looked at in REQ once the ack lands.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (halt)       state_nxt = ST_HALT;
        else if (stall) state_nxt = ST_IDLE;
        else            state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (halt)       state_nxt = ST_HALT;
          else if (stall) state_nxt = ST_IDLE;
          else            state_nxt = ST_REQ;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req = (state == ST_REQ);
    halted   = (state == ST_HALT);
  end

  // PC, pending redirect and decode-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      inst_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!halt && branch_taken) begin
            pc_q <= branch_target;
          end
        end
        ST_REQ: begin
          if (!imem_ack) begin
            // Latest redirect during the wait wins.
            if (branch_taken) begin
              pend_valid <= 1'b1;
              pend_tgt   <= branch_target;
            end
          end else if (redirect) begin
            pc_q       <= branch_taken ? branch_target : pend_tgt;
            pend_valid <= 1'b0;
          end else begin
            inst_valid <= 1'b1;
            inst_out   <= imem_rdata;
            inst_pc    <= pc_q;
            pc_q       <= pc_q + PC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a behavioural
// fetch model; includes mid-cycle asynchronous resets and PC wrap-around.
module tb_pc_fetch_unit;

  localparam int          AW       = 9;
  localparam int          DW       = 32;
  localparam int          PC_MOD   = 1 << AW;
  localparam logic [AW-1:0] RST_PC = 9'h010;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          halt;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          halted;

  pc_fetch_unit #(
    .INST_ADDR_WIDTH(AW),
    .INST_WIDTH     (DW),
    .RESET_PC       (RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: just-reset flag, fetch-in-flight flag, halted flag,
  // pending redirect target (-1 = none) and the decode-side view.
  bit   m_boot;
  bit   m_fetch;
  bit   m_halt;
  int   m_pc;
  int   m_pend;
  bit   m_vld;
  logic [DW-1:0] m_out;
  int   m_ipc;

  int ack_pct, stall_pct, br_pct;
  bit halt_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_fetch = 1'b0;
    m_halt  = 1'b0;
    m_pc    = int'(RST_PC);
    m_pend  = -1;
    m_vld   = 1'b0;
    m_out   = '0;
    m_ipc   = 0;
  endtask

  task automatic check_outputs();
    chk("imem_req",   32'(imem_req),   32'(!m_boot && !m_halt && m_fetch));
    chk("imem_addr",  32'(imem_addr),  32'(m_pc));
    chk("halted",     32'(halted),     32'(m_halt));
    chk("inst_valid", 32'(inst_valid), 32'(m_vld));
    chk("inst_out",   32'(inst_out),   m_out);
    chk("inst_pc",    32'(inst_pc),    32'(m_ipc));
  endtask

  // Predict the effect of the inputs applied for the coming clock edge.
  task automatic model_step();
    m_vld = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      // nothing moves until reset
    end else if (!m_fetch) begin
      if (halt) begin
        m_halt = 1'b1;
      end else begin
        if (branch_taken) m_pc = int'(branch_target);
        m_fetch = !stall;
      end
    end else if (!imem_ack) begin
      if (branch_taken) m_pend = int'(branch_target);
    end else begin
      if (branch_taken || m_pend >= 0) begin
        m_pc   = branch_taken ? int'(branch_target) : m_pend;
        m_pend = -1;
      end else begin
        m_vld = 1'b1;
        m_out = imem_rdata;
        m_ipc = m_pc;
        m_pc  = (m_pc + 1) % PC_MOD;
      end
      if (halt)       begin m_halt = 1'b1; m_fetch = 1'b0; end
      else if (stall) m_fetch = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    imem_ack     = ($urandom_range(0, 99) < ack_pct);
    imem_rdata   = $urandom;
    stall        = ($urandom_range(0, 99) < stall_pct);
    branch_taken = ($urandom_range(0, 99) < br_pct);
    halt         = halt_en && ($urandom_range(0, 199) == 0);
    case ($urandom_range(0, 3))
      0:       branch_target = 9'h1FF;
      1:       branch_target = 9'h1FE;
      default: branch_target = AW'($urandom);
    endcase
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    model_reset();
    for (int seg = 0; seg < 14; seg++) begin
      // first segment: ack tied high, no stall/branch/halt -> straight-line fetch
      if (seg == 0) begin
        ack_pct = 100; stall_pct = 0; br_pct = 0; halt_en = 1'b0;
      end else begin
        ack_pct   = $urandom_range(30, 100);
        stall_pct = $urandom_range(0, 40);
        br_pct    = $urandom_range(0, 30);
        halt_en   = (seg % 3 != 1);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        check_outputs();
        drive_inputs();
        model_step();
        @(negedge clk);
      end
      // asynchronous reset landing between clock edges
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
